vga_pixel_unpack: RTL
=====================

Name: vga_pixel_unpack

Overview:
- Colour-processing stage between the framebuffer data FIFO (fb_data_fifo) and the line FIFO in the wb_clk_i domain.
- Pops 32-bit framebuffer words and unpacks them into 24-bit RGB pixels according to colour depth. Supported modes: 8bpp greyscale, 8bpp pseudo-colour via CLUT, 16bpp RGB565, packed 24bpp, 32bpp.
- Writes one pixel per line_fifo_wreq into the line FIFO, which the pixel-clock side drains.

Parameters:
- FB_DW, 32, framebuffer word width (only 32 supported).
- PIX_W, 24, output pixel width {R[7:0],G[7:0],B[7:0]}.
- CLUT_AW, 8, CLUT address width.

Ports:
- wb_clk_i  in  1  sole clock.
- rst_i  in  1  reset; asynchronous, active-high.
- ctrl_ven  in  1  video enable; low = synchronous flush/idle.
- ctrl_cd  in  2  colour depth: 00 8bpp, 01 16bpp, 10 24bpp, 11 32bpp; changes only while ctrl_ven low.
- ctrl_pc  in  1  8bpp only: 1 = pseudo-colour (CLUT), 0 = greyscale.
- fb_data_fifo_q  in  32  show-ahead head word, valid while !fb_data_fifo_empty.
- fb_data_fifo_empty  in  1  FIFO empty.
- fb_data_fifo_rreq  out  1  pop; combinational; never high while empty or ctrl_ven low.
- line_fifo_full_wr  in  1  line FIFO full; asserts with at least one free entry remaining.
- line_fifo_wreq  out  1  registered write strobe, one pixel per cycle high.
- line_fifo_d  out  24  registered pixel, valid with line_fifo_wreq.
- clut_req  out  1  CLUT lookup request.
- clut_adr  out  8  CLUT index.
- clut_ack  in  1  CLUT data valid.
- clut_q  in  24  CLUT RGB.

Behaviour:
- Reset (async):
  - line_fifo_wreq=0, line_fifo_d=0, clut_req=0, clut_adr=0.
  - Word buffer empty, pixel index=0, residue register=0, state IDLE.
- ctrl_ven low:
  - Same clear as reset, applied synchronously.
  - No rreq, wreq or clut_req.
- Word buffer: one 32-bit word plus valid flag.
  - rreq=1 when (buffer empty, or last pixel of the buffered word issued this cycle) and !fb_data_fifo_empty and ctrl_ven.
  - The word is captured on that edge.
- Pixel issue:
  - A pixel is issued at edge t only if the buffer is valid and line_fifo_full_wr was low at t.
  - line_fifo_wreq/line_fifo_d are high/valid in cycle t+1.
  - First pixel appears one cycle after the pop edge.
  - Sustained throughput is 1 pixel/clk in non-CLUT modes.
- Pixel order within a word is MSB first.
- 8bpp grey: byte b -> {b,b,b}; 4 pixels/word (31:24 first).
- 8bpp CLUT: state LOOKUP.
  - Assert clut_req with clut_adr=byte; hold both stable until clut_ack.
  - On ack, register clut_q as the pixel (subject to the full check; if full, hold the pixel in the output stage until !full).
  - One lookup outstanding; clut_req drops the cycle after ack.
  - The next lookup may start that cycle.
- 16bpp: halfword {r5,g6,b5} -> {r5,r5[4:2], g6,g6[5:4], b5,b5[4:2]}; 2 pixels/word, 31:16 first.
- 24bpp: 3 words -> 4 pixels, phase counter 0..3 (wraps 3->0):
  - p0 = w0[31:8].
  - p1 = {w0[7:0], w1[31:16]}.
  - p2 = {w1[15:0], w2[31:24]}.
  - p3 = w2[23:0].
  - Residue register (16b) carries leftover bytes across words.
  - A phase needing a new word stalls until popped.
- 32bpp: word[23:0]; bits 31:24 ignored; 1 pixel/word.
- Stall rules:
  - FIFO empty: hold current state, no wreq.
  - line_fifo_full_wr high: hold, no new issue.
  - Both high: hold. No pixel is lost or duplicated.
- ctrl_ven falling mid-line or mid-lookup:
  - Abandon the lookup (clut_req=0 next cycle) and discard the buffer and residue.
  - A clut_ack arriving after abandonment is ignored.

Decomposition:
- Shared package vga_pkg:
  - cd_e enum (CD_8, CD_16, CD_24, CD_32).
  - unpack-state enum (IDLE, RUN, LOOKUP).
  - PIX_W and CLUT_AW constants.
- One sub-module, vga_rgb565_expand: combinational 16->24 bit-replication, reused by the verification model.

Test Plan:
- 8bpp grey, FIFO holds 0x11223344, line FIFO never full -> rreq pulse at t; wreq at t+1..t+4 with 0x111111, 0x222222, 0x333333, 0x444444.
- 24bpp, words 0xAABBCCDD, 0xEEFF0011, 0x22334455 -> pixels 0xAABBCC, 0xDDEEFF, 0x001122, 0x334455 in order; phase returns to 0.
- 16bpp word 0xF800_07E0 -> 0xFF0000 then 0x00FF00; with line_fifo_full_wr high for 3 cycles between them, second wreq is delayed exactly 3 cycles and written once.
- 8bpp CLUT byte 0x05, clut_ack after 4 cycles with clut_q=0x123456 -> clut_adr=0x05 stable for 4 cycles; wreq with 0x123456 in the cycle after ack.
- 32bpp continuous words, FIFO never empty -> one pixel per clock, no gaps, top byte dropped (0xFF102030 -> 0x102030).
- ctrl_ven dropped mid-24bpp group (phase 2) then re-enabled -> no wreq while low; first pixel after re-enable is p0 of the next popped word.
- rst_i asserted mid-lookup (asynchronously, between edges) -> clut_req and line_fifo_wreq go low immediately.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel unpack stage.
//   cd_e    : colour-depth encoding as carried on ctrl_cd
//   state_e : unpack-engine states
//   PIX_W   : output pixel width {R,G,B}
//   CLUT_AW : CLUT index width
package vga_pkg;

    localparam int unsigned FB_DW   = 32;
    localparam int unsigned PIX_W   = 24;
    localparam int unsigned CLUT_AW = 8;
    localparam int unsigned RES_W   = 16;

    typedef enum logic [1:0] {
        CD_8  = 2'b00,
        CD_16 = 2'b01,
        CD_24 = 2'b10,
        CD_32 = 2'b11
    } cd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        LOOKUP = 2'b10
    } state_e;

    // Greyscale byte replicated onto all three channels.
    function automatic logic [PIX_W-1:0] grey8(input logic [7:0] b);
        return {b, b, b};
    endfunction

endpackage

// File: rtl/vga_rgb565_expand.sv
// RGB565 -> RGB888 expansion by MSB replication (purely combinational).
//   i_rgb565   : {r5, g6, b5}
//   o_rgb888_c : {r5,r5[4:2], g6,g6[5:4], b5,b5[4:2]}
module vga_rgb565_expand
    import vga_pkg::*;
(
    input  logic [15:0]      i_rgb565,
    output logic [PIX_W-1:0] o_rgb888_c
);

    assign o_rgb888_c = {i_rgb565[15:11], i_rgb565[15:13],
                         i_rgb565[10:5],  i_rgb565[10:9],
                         i_rgb565[4:0],   i_rgb565[4:2]};

endmodule

// File: rtl/vga_pixel_unpack.sv
// Framebuffer word -> RGB pixel unpacker feeding the line FIFO.
//   wb_clk_i, rst_i         : clock, async active-high reset
//   ctrl_ven/cd/pc          : video enable, colour depth, pseudo-colour select
//   fb_data_fifo_*          : show-ahead word FIFO (q, empty, combinational rreq)
//   line_fifo_*             : line FIFO full input, registered wreq/d
//   clut_req/adr/ack/q      : CLUT lookup handshake
module vga_pixel_unpack #(
    parameter int unsigned FB_DW   = vga_pkg::FB_DW,
    parameter int unsigned PIX_W   = vga_pkg::PIX_W,
    parameter int unsigned CLUT_AW = vga_pkg::CLUT_AW
) (
    input  logic               wb_clk_i,
    input  logic               rst_i,
    input  logic               ctrl_ven,
    input  logic [1:0]         ctrl_cd,
    input  logic               ctrl_pc,
    input  logic [FB_DW-1:0]   fb_data_fifo_q,
    input  logic               fb_data_fifo_empty,
    output logic               fb_data_fifo_rreq,
    input  logic               line_fifo_full_wr,
    output logic               line_fifo_wreq,
    output logic [PIX_W-1:0]   line_fifo_d,
    output logic               clut_req,
    output logic [CLUT_AW-1:0] clut_adr,
    input  logic               clut_ack,
    input  logic [PIX_W-1:0]   clut_q
);

    import vga_pkg::*;

    state_e               r_state, w_state_nxt;
    cd_e                  w_cd;
    logic [FB_DW-1:0]     r_buf;
    logic                 r_buf_vld;
    logic [1:0]           r_idx;
    logic [RES_W-1:0]     r_res;
    logic                 r_pend;
    logic                 r_wreq;
    logic [PIX_W-1:0]     r_d;
    logic                 r_clut_req;
    logic [CLUT_AW-1:0]   r_clut_adr;

    logic                 w_clut_mode, w_avail, w_last, w_issue, w_look, w_ack, w_release;
    logic                 w_adv, w_consume, w_rreq, w_load;
    logic [FB_DW-1:0]     w_word;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [PIX_W-1:0]     w_pix, w_pix565;

    assign w_cd        = cd_e'(ctrl_cd);
    assign w_clut_mode = (w_cd == CD_8) && ctrl_pc;

    // Empty buffer bypasses the FIFO head so the first pixel issues on the pop edge.
    assign w_word  = r_buf_vld ? r_buf : fb_data_fifo_q;
    assign w_avail = r_buf_vld || (ctrl_ven && !fb_data_fifo_empty);

    // State register.
    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and per-cycle action strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_look      = 1'b0;
        w_ack       = 1'b0;
        w_release   = 1'b0;
        if (!ctrl_ven) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = RUN;
                RUN: begin
                    if (w_clut_mode) begin
                        if (r_pend) begin
                            w_release = !line_fifo_full_wr;
                        end else if (w_avail) begin
                            w_look      = 1'b1;
                            w_state_nxt = LOOKUP;
                        end
                    end else if (w_avail && !line_fifo_full_wr) begin
                        w_issue = 1'b1;
                    end
                end
                LOOKUP: begin
                    if (clut_ack) begin
                        w_ack       = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Last pixel of the current word; in 24bpp only phase 2 leaves the word buffered.
    always_comb begin
        w_last = 1'b1;
        case (w_cd)
            CD_8:  w_last = (r_idx == 2'd3);
            CD_16: w_last = r_idx[0];
            CD_24: w_last = (r_idx != 2'd2);
            CD_32: w_last = 1'b1;
        endcase
    end

    assign w_adv             = w_issue || w_look;
    assign w_consume         = w_adv && w_last;
    assign w_rreq            = ctrl_ven && !fb_data_fifo_empty && (!r_buf_vld || w_consume);
    assign w_load            = w_rreq && !(!r_buf_vld && w_consume);
    assign fb_data_fifo_rreq = w_rreq;

    // Pixel selection, MSB first within the word.
    always_comb begin
        w_byte = w_word[31:24];
        case (r_idx)
            2'd0: w_byte = w_word[31:24];
            2'd1: w_byte = w_word[23:16];
            2'd2: w_byte = w_word[15:8];
            2'd3: w_byte = w_word[7:0];
        endcase
    end

    assign w_half = r_idx[0] ? w_word[15:0] : w_word[31:16];

    vga_rgb565_expand u_expand (
        .i_rgb565   (w_half),
        .o_rgb888_c (w_pix565)
    );

    always_comb begin
        w_pix = w_word[23:0];
        case (w_cd)
            CD_8:  w_pix = grey8(w_byte);
            CD_16: w_pix = w_pix565;
            CD_24: begin
                case (r_idx)
                    2'd0: w_pix = w_word[31:8];
                    2'd1: w_pix = {r_res[7:0], w_word[31:16]};
                    2'd2: w_pix = {r_res, w_word[31:24]};
                    2'd3: w_pix = w_word[23:0];
                endcase
            end
            CD_32: w_pix = w_word[23:0];
        endcase
    end

    // Datapath: word buffer, pixel index/residue, CLUT handshake, output stage.
    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_buf      <= '0;
            r_buf_vld  <= 1'b0;
            r_idx      <= 2'd0;
            r_res      <= '0;
            r_pend     <= 1'b0;
            r_wreq     <= 1'b0;
            r_d        <= '0;
            r_clut_req <= 1'b0;
            r_clut_adr <= '0;
        end else if (!ctrl_ven) begin
            r_buf      <= '0;
            r_buf_vld  <= 1'b0;
            r_idx      <= 2'd0;
            r_res      <= '0;
            r_pend     <= 1'b0;
            r_wreq     <= 1'b0;
            r_d        <= '0;
            r_clut_req <= 1'b0;
            r_clut_adr <= '0;
        end else begin
            r_wreq <= w_issue || w_release || (w_ack && !line_fifo_full_wr);

            if (w_issue)    r_d <= w_pix;
            else if (w_ack) r_d <= clut_q;

            // A CLUT result landing while full waits in the output stage.
            if (w_ack && line_fifo_full_wr) r_pend <= 1'b1;
            else if (w_release)             r_pend <= 1'b0;

            if (w_look) begin
                r_clut_req <= 1'b1;
                r_clut_adr <= CLUT_AW'(w_byte);
            end else if (w_ack) begin
                r_clut_req <= 1'b0;
            end

            if (w_load) begin
                r_buf     <= fb_data_fifo_q;
                r_buf_vld <= 1'b1;
            end else if (w_consume) begin
                r_buf_vld <= 1'b0;
            end

            if (w_adv) begin
                if ((w_cd == CD_32) || ((w_cd == CD_16) && r_idx[0])) r_idx <= 2'd0;
                else                                                  r_idx <= r_idx + 2'd1;
            end

            // 24bpp leftovers: one byte after phase 0, a halfword after phase 1.
            if (w_issue && (w_cd == CD_24)) begin
                if (r_idx == 2'd0)      r_res <= {8'h00, w_word[7:0]};
                else if (r_idx == 2'd1) r_res <= w_word[15:0];
            end
        end
    end

    assign line_fifo_wreq = r_wreq;
    assign line_fifo_d    = r_d;
    assign clut_req       = r_clut_req;
    assign clut_adr       = r_clut_adr;

endmodule
